// File: rtl/fifo_drain_if.sv
// fifo_drain_if: FIFO-array pop/bit port plus the valid/ready word port of fifo_drain.
interface fifo_drain_if #(
    parameter int NCH   = 12,
    parameter int WIDTH = 64
);
    logic [1:NCH]                 fifo_empty;
    logic [1:NCH]                 fifo_req;
    logic                         fifo_bit;
    logic [WIDTH-1:0]             out_data;
    logic [$clog2(NCH + 1)-1:0]   out_chan;
    logic                         out_valid;
    logic                         out_ready;
    modport master (
        input  fifo_empty, fifo_bit, out_ready,
        output fifo_req, out_data, out_chan, out_valid
    );
    modport slave (
        output fifo_empty, fifo_bit, out_ready,
        input  fifo_req, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/fifo_drain.sv
// fifo_drain: round-robin drain of NCH serial result FIFOs into a valid/ready word port.
// Define FIFO_DRAIN_MASK_EN to add the chan_en_i arbitration mask.
module fifo_drain #(
    parameter int NCH      = 12,
    parameter int WIDTH    = 64,
    parameter int READ_LAT = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
`ifdef FIFO_DRAIN_MASK_EN
    input  logic [1:NCH] chan_en_i,
`endif
    fifo_drain_if.master bus
);
    localparam int CW = $clog2(NCH + 1);
    localparam int BW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, OUT} state_t;
    state_t              state_q;
    logic [1:NCH]        cand;
    logic [1:NCH]        req_d;
    logic [1:NCH]        req_q;
    logic [CW-1:0]       grant_d;
    logic [CW-1:0]       cur_q;
    logic [CW-1:0]       rr_q;
    logic [BW-1:0]       bitcnt_q;
    logic [READ_LAT-1:0] act_q;
    logic [WIDTH-1:0]    sr_q;
    logic                valid_q;
`ifdef FIFO_DRAIN_MASK_EN
    assign cand = ~bus.fifo_empty & chan_en_i;
`else
    assign cand = ~bus.fifo_empty;
`endif
    // Lowest candidate at or above rr_q wins; otherwise wrap to the lowest candidate overall.
    always_comb begin
        grant_d = '0;
        req_d   = '0;
        for (int k = NCH; k >= 1; k--)
            if (cand[k]) grant_d = CW'(k);
        for (int k = NCH; k >= 1; k--)
            if (cand[k] && CW'(k) >= rr_q) grant_d = CW'(k);
        for (int k = 1; k <= NCH; k++)
            req_d[k] = (grant_d == CW'(k));
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            req_q    <= '0;
            cur_q    <= CW'(1);
            rr_q     <= CW'(1);
            bitcnt_q <= '0;
            act_q    <= '0;
            sr_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            // The delay line tracks which cycles carry a returning bit on fifo_bit.
            act_q <= READ_LAT'({act_q, |req_q});
            if (act_q[READ_LAT-1]) sr_q <= {sr_q[WIDTH-2:0], bus.fifo_bit};
            case (state_q)
                IDLE: if (|cand) begin
                    cur_q    <= grant_d;
                    req_q    <= req_d;
                    bitcnt_q <= BW'(WIDTH);
                    state_q  <= SHIFT;
                end
                SHIFT: begin
                    bitcnt_q <= bitcnt_q - BW'(1);
                    if (bitcnt_q == BW'(1)) begin
                        req_q    <= '0;
                        bitcnt_q <= BW'(READ_LAT);
                        state_q  <= FLUSH;
                    end
                end
                FLUSH: begin
                    bitcnt_q <= bitcnt_q - BW'(1);
                    if (bitcnt_q == BW'(1)) begin
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end
                end
                OUT: if (bus.out_ready) begin
                    valid_q <= 1'b0;
                    rr_q    <= (cur_q == CW'(NCH)) ? CW'(1) : cur_q + CW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.fifo_req  = req_q;
    assign bus.out_data  = sr_q;
    assign bus.out_chan  = cur_q;
    assign bus.out_valid = valid_q;
endmodule
